// File: rtl/svc_latency_buf_pkg.sv
// Shared helpers for svc_latency_buf and other small FIFOs.
// Pointer increment with explicit wrap so any DEPTH works.
package svc_latency_buf_pkg;

    function automatic int unsigned ptr_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/svc_latency_buf_if.sv
// Issue, result, stream and credit signals of svc_latency_buf.
// slave = buffer side, master = pipeline/consumer side.
interface svc_latency_buf_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             issue_valid;
    logic             issue_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [CW-1:0]    credits;

    modport slave (
        input  issue_valid,
        input  res_valid,
        input  res_data,
        input  m_ready,
        output issue_ready,
        output m_valid,
        output m_data,
        output credits
    );

    modport master (
        output issue_valid,
        output res_valid,
        output res_data,
        output m_ready,
        input  issue_ready,
        input  m_valid,
        input  m_data,
        input  credits
    );

endinterface

// File: rtl/svc_credit_cnt.sv
// Free-credit counter: reset to DEPTH, launch takes one,
// return gives one back, both together leave it unchanged.
module svc_credit_cnt #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_launch,
    input  logic                       i_return,
    output logic [$clog2(DEPTH+1)-1:0] o_credits,
    output logic                       o_has_credit
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_credits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CW'(DEPTH);
        end else if (i_launch && !i_return) begin
            r_credits <= r_credits - CW'(1);
        end else if (i_return && !i_launch) begin
            r_credits <= r_credits + CW'(1);
        end
    end

    assign o_credits    = r_credits;
    assign o_has_credit = (r_credits != '0);

endmodule

// File: rtl/svc_latency_buf.sv
// Credit-gated result buffer behind a fixed-latency pipeline.
// Optional same-cycle bypass: SVC_LATENCY_BUF_BYPASS_EN.
module svc_latency_buf
    import svc_latency_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    svc_latency_buf_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic          w_empty;
    logic          w_full;
    logic          w_pop_fifo;
    logic          w_bypass;
    logic          w_pop;
    logic          w_wr;
    logic          w_launch;
    logic          w_has_credit;
    logic [CW-1:0] w_credits;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop_fifo = bus.m_ready && !w_empty;

`ifdef SVC_LATENCY_BUF_BYPASS_EN
    assign w_bypass    = w_empty && bus.res_valid && bus.m_ready;
    assign bus.m_valid = !w_empty || bus.res_valid;
    assign bus.m_data  = w_empty ? bus.res_data
                                 : r_mem[r_rd_ptr];
`else
    assign w_bypass    = 1'b0;
    assign bus.m_valid = !w_empty;
    assign bus.m_data  = r_mem[r_rd_ptr];
`endif

    // A full FIFO still accepts a write when it pops that cycle.
    assign w_pop  = w_pop_fifo || w_bypass;
    assign w_wr   = bus.res_valid && !w_bypass
                    && (!w_full || w_pop_fifo);

    assign w_launch        = bus.issue_valid && w_has_credit;
    assign bus.issue_ready = w_has_credit;
    assign bus.credits     = w_credits;

    svc_credit_cnt #(
        .DEPTH (DEPTH)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .i_launch     (w_launch),
        .i_return     (w_pop),
        .o_credits    (w_credits),
        .o_has_credit (w_has_credit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= AW'(ptr_inc(32'(r_wr_ptr),
                                        32'(DEPTH)));
            end
            if (w_pop_fifo) begin
                r_rd_ptr <= AW'(ptr_inc(32'(r_rd_ptr),
                                        32'(DEPTH)));
            end
            if (w_wr && !w_pop_fifo) begin
                r_count <= r_count + CW'(1);
            end else if (!w_wr && w_pop_fifo) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[r_wr_ptr] <= bus.res_data;
        end
    end

endmodule

// File: tb/tb_svc_latency_buf.sv
// Bench for svc_latency_buf behind a 3-cycle delay line, DEPTH=4.
// Directed table, corner sequences and random traffic vs a queue model.
module tb_svc_latency_buf;

    localparam int DEPTH = 4;
`ifdef SVC_LATENCY_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    svc_latency_buf_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    svc_latency_buf #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] iss_d  = 8'h00;
    logic       inj_en = 1'b0;
    logic [7:0] inj_d  = 8'h00;
    logic [2:0] dl_v   = 3'b000;
    logic [7:0] dl_d [3];

    // Delay line is flushed with the buffer, as the upstream must do.
    always @(posedge clk) begin
        if (rst) begin
            dl_v <= 3'b000;
        end else begin
            dl_v    <= {dl_v[1:0],
                        bus.issue_valid && bus.issue_ready};
            dl_d[0] <= iss_d;
            dl_d[1] <= dl_d[0];
            dl_d[2] <= dl_d[1];
        end
    end

    assign bus.res_valid = inj_en || dl_v[2];
    assign bus.res_data  = inj_en ? inj_d : dl_d[2];

    typedef struct {
        logic [7:0] d;
        int         due;
    } fl_t;

    typedef struct {
        bit         r;
        bit         iv;
        logic [7:0] d;
        bit         mr;
        bit         ck;
        bit         rdy;
        bit         mv;
        logic [2:0] cr;
        logic [7:0] md;
    } vec_t;

    fl_t        infl[$];
    logic [7:0] fifo_q[$];
    vec_t       tbl[$];
    int         cred_m = DEPTH;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       s_rdy;
    logic       s_mv;
    logic [7:0] s_md;
    logic [2:0] s_cr;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, sample at negedge, check, advance model.
    task automatic step(input bit r, input bit iv,
                        input logic [7:0] d, input bit mr,
                        input bit inj = 1'b0,
                        input logic [7:0] idat = 8'h00);
        bit         rv;
        logic [7:0] rd;
        bit         em;
        bit         ev;
        bit         launch;
        bit         pop;
        bit         byp;
        rst             = r;
        bus.issue_valid = iv;
        iss_d           = d;
        bus.m_ready     = mr;
        inj_en          = inj;
        inj_d           = idat;
        @(negedge clk);
        s_rdy = bus.issue_ready;
        s_mv  = bus.m_valid;
        s_md  = bus.m_data;
        s_cr  = bus.credits;
        rv = 1'b0;
        rd = 8'h00;
        if (inj) begin
            rv = 1'b1;
            rd = idat;
        end else if (infl.size() != 0 && infl[0].due == cyc) begin
            rv = 1'b1;
            rd = infl[0].d;
            void'(infl.pop_front());
        end
        em = (fifo_q.size() == 0);
        ev = !em || (BYP && rv);
        if (!r) begin
            check("credits", 32'(s_cr), 32'(cred_m));
            check("issue_ready", 32'(s_rdy), 32'(cred_m != 0));
            check("m_valid", 32'(s_mv), 32'(ev));
            if (ev) begin
                check("m_data", 32'(s_md),
                      32'(em ? rd : fifo_q[0]));
            end
        end
        if (r) begin
            infl.delete();
            fifo_q.delete();
            cred_m = DEPTH;
        end else begin
            launch = iv && (cred_m != 0);
            pop    = ev && mr;
            byp    = BYP && em && rv && mr;
            if (pop && !byp) void'(fifo_q.pop_front());
            if (rv && !byp && fifo_q.size() < DEPTH) begin
                fifo_q.push_back(rd);
            end
            cred_m = cred_m + int'(pop) - int'(launch);
            if (launch) infl.push_back('{d, cyc + 3});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic vec_t mk(bit r, bit iv, logic [7:0] d,
                                bit mr, bit ck, bit rdy, bit mv,
                                logic [2:0] cr, logic [7:0] md);
        vec_t v;
        v = '{r, iv, d, mr, ck, rdy, mv, cr, md};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bus.issue_valid = 1'b0;
        bus.m_ready     = 1'b0;
        // reset, then single item A5 with m_ready high
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 3'd4, 8'h00));
        tbl.push_back(mk(0, 1, 8'hA5, 1, 1, 1, 0, 3'd4, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 3'd3, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 3'd3, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, BYP, 3'd3, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, !BYP,
                         BYP ? 3'd4 : 3'd3, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 3'd4, 8'h00));
        // backpressure fill with 01..06 offered
        tbl.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, 3'd4, 8'h00));
        tbl.push_back(mk(0, 1, 8'h02, 0, 1, 1, 0, 3'd3, 8'h00));
        tbl.push_back(mk(0, 1, 8'h03, 0, 1, 1, 0, 3'd2, 8'h00));
        tbl.push_back(mk(0, 1, 8'h04, 0, 1, 1, BYP, 3'd1, 8'h01));
        tbl.push_back(mk(0, 1, 8'h05, 0, 1, 0, 1, 3'd0, 8'h01));
        tbl.push_back(mk(0, 1, 8'h06, 0, 1, 0, 1, 3'd0, 8'h01));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 3'd0, 8'h01));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 3'd0, 8'h01));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].mr);
            if (tbl[i].ck) begin
                check("tbl_ready", 32'(s_rdy), 32'(tbl[i].rdy));
                check("tbl_credits", 32'(s_cr), 32'(tbl[i].cr));
                check("tbl_m_valid", 32'(s_mv), 32'(tbl[i].mv));
                if (tbl[i].mv) begin
                    check("tbl_m_data", 32'(s_md), 32'(tbl[i].md));
                end
            end
        end

        // drain from full while launching every cycle
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
            check("drain_cred_le1", 32'(s_cr <= 3'd1), 32'd1);
        end

        // refill, then write+pop while full, then a dropped write
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        end
        check("refill_cred", 32'(s_cr), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hE1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE2);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end

        // reset with 2 buffered and 2 in flight
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'(8'h31 + i), 1'b0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_credits", 32'(s_cr), 32'd4);
        check("rst_m_valid", 32'(s_mv), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            check("rst_discard", 32'(s_mv), 32'd0);
        end

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 79) == 0,
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/svc_latency_buf.md
Name: svc_latency_buf

Overview:
- Downstream companion to a fixed-latency delay pipeline with no backpressure (e.g. an N-cycle delay line with a valid bit alongside).
- Grants issue slots upstream only while buffer space is guaranteed, using a credit counter.
- Captures every result that emerges from the pipeline into a FIFO and re-presents it on a valid/ready interface.
- Turns a non-stallable pipeline into a stallable stream without dropping data.

Parameters:
- WIDTH, 8, result data width in bits.
- DEPTH, 4, FIFO entries and total credits; legal range 2..256, need not be a power of two.
- CW, $clog2(DEPTH+1), credit counter width (derived, do not override).
- AW, $clog2(DEPTH), FIFO pointer width (derived, do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  upstream wants to launch an item into the pipeline.
- issue_ready  out  1  credit available; launch occurs when issue_valid && issue_ready.
- res_valid  in  1  pipeline output valid, arriving a fixed number of cycles after a launch.
- res_data  in  WIDTH  pipeline output data.
- m_valid  out  1  buffered result available.
- m_data  out  WIDTH  buffered result, head of FIFO.
- m_ready  in  1  consumer accepts; pop on m_valid && m_ready.
- credits  out  CW  current free credits, for debug and bench checks.

Behaviour:
- Reset (rst high at posedge):
  - credits = DEPTH; issue_ready = 1; m_valid = 0.
  - FIFO count, rd_ptr and wr_ptr = 0.
  - m_data is don't-care; the bench must not check it while m_valid = 0.
  - Results arriving while rst is high are discarded. The upstream must flush the pipeline alongside this block.
- Credit accounting:
  - issue_ready = (credits != 0), purely combinational from the register.
  - Launch: credits decrements by 1. Pop: credits increments by 1. Launch and pop in the same cycle: unchanged.
  - Invariant: credits + in_flight + fifo_count == DEPTH.
  - credits never exceeds DEPTH and never goes below 0.
- FIFO:
  - res_valid writes res_data at wr_ptr, then wr_ptr advances.
  - Pop advances rd_ptr.
  - Both pointers wrap from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
  - count updates: +1 on write only, -1 on pop only, unchanged on both.
  - Write and pop in the same cycle are legal at any count, including full (DEPTH) and empty with bypass.
- Output:
  - Default: m_valid = (count != 0); m_data = mem[rd_ptr].
  - Latency from res_valid to m_valid is 1 cycle.
- Protocol errors:
  - res_valid while count == DEPTH with no pop that cycle cannot occur when credits are honoured. The write is dropped and state is not corrupted.
  - A pop while m_valid = 0 is ignored.
- Arithmetic: all counters are unsigned with no saturation logic; correctness relies on the invariant above.
- State: the block is a pure counter/pointer datapath with no FSM. Storage is a register array (DEPTH x WIDTH); no RAM inference is required.

Optional Feature:
- Macro: SVC_LATENCY_BUF_BYPASS_EN.
- Defined:
  - When count == 0 and res_valid = 1, m_valid = 1 and m_data = res_data combinationally in the same cycle.
  - If m_ready is also high, the item is consumed, not written, and credits increments (a pop).
  - If m_ready is low, the item is written normally.
  - res-to-m latency is 0 cycles.
- Undefined: the behaviour is as specified above, with a 1-cycle minimum latency and no combinational res-to-m path.

Decomposition:
- Package svc_latency_buf_pkg: no typedefs needed. CW/AW are derived locally. The pointer-increment-with-wrap helper is a function in the package, reusable by other FIFOs.
- One sub-module is natural: svc_credit_cnt (launch/return inputs, credits and has_credit outputs, reset to DEPTH). The FIFO stays inline.

Test Plan (bench instantiates a CYCLES=3 delay line between issue and res, valid bit delayed with the data, DEPTH=4):
- Reset: credits == 4, issue_ready == 1, m_valid == 0.
- Single item:
  - Stimulus: launch 8'hA5 with m_ready = 1.
  - Default build: m_valid rises 4 cycles after launch with m_data == 8'hA5; credits returns to 4 the cycle after the pop.
  - BYPASS build: m_valid rises 3 cycles after launch.
- Backpressure fill:
  - Stimulus: m_ready = 0; issue_valid held high with data 8'h01..8'h06.
  - Exactly 4 launches accepted (8'h01..8'h04); issue_ready == 0 from cycle 4 onward. After the pipeline drains, count == 4 and credits == 0.
- Drain with simultaneous launch:
  - Stimulus: from the full state, m_ready = 1 and issue_valid = 1 continuously.
  - Outputs 8'h01, 8'h02, ... appear in order with no loss or duplication. credits stays within 0..1; pointers wrap past index 3.
- Full + write + pop: with count == 4 and res_valid arriving in the same cycle as a pop -> count stays 4 and order is preserved.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle with 2 items in flight and 2 buffered.
  - Next cycle: credits == 4 and m_valid == 0. Results still exiting the delay line during rst are discarded.
